// File: rtl/cpu_flags_pkg.sv
// Shared flag-register definitions: bit positions of the architectural flags
// and the default register width used across the CPU datapath.
package cpu_flags_pkg;

    localparam int CF_IDX = 3;
    localparam int OF_IDX = 2;
    localparam int NF_IDX = 1;
    localparam int ZF_IDX = 0;

    localparam int NFLAGS_DEFAULT = 4;

    typedef logic [NFLAGS_DEFAULT-1:0] flags_t;

endpackage

// File: rtl/flag_lifo.sv
// DEPTH-entry LIFO of flag words with push, pop and in-place exchange of the top.
// Entries are not reset; only the occupancy count is.
module flag_lifo
    import cpu_flags_pkg::*;
#(
    parameter int NFLAGS = NFLAGS_DEFAULT,
    parameter int DEPTH  = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [NFLAGS-1:0] din_i,
    output logic [NFLAGS-1:0] top_o,
    output logic [CW-1:0]     count_o,
    output logic              empty_o,
    output logic              full_o
);

    logic [NFLAGS-1:0] mem_q [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic [IW-1:0]     top_idx, wr_idx;
    logic              do_push, do_pop, do_xchg;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    // Push+pop on an empty stack degrades to a plain push; exchange is legal when full.
    assign do_xchg = push_i && pop_i && !empty_o;
    assign do_push = push_i && !do_xchg && !full_o;
    assign do_pop  = pop_i && !push_i && !empty_o;

    assign top_idx = IW'(count_q - CW'(1));
    assign wr_idx  = IW'(count_q);
    assign top_o   = mem_q[top_idx];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_idx] <= din_i;
        end else if (do_xchg) begin
            mem_q[top_idx] <= din_i;
        end
    end

endmodule

// File: rtl/flag_stack_unit.sv
// Status-flag register with masked load, per-bit set/clear, and a save/restore
// stack; a valid pop overrides every other flag update in the same cycle.
module flag_stack_unit
    import cpu_flags_pkg::*;
#(
    parameter int                NFLAGS    = NFLAGS_DEFAULT,
    parameter int                DEPTH     = 4,
    parameter logic [NFLAGS-1:0] RESET_VAL = '0,
    localparam int               CW        = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NFLAGS-1:0] FLAGS_IN,
    input  logic              FWE,
    input  logic [NFLAGS-1:0] FMASK,
    input  logic [NFLAGS-1:0] FSET,
    input  logic [NFLAGS-1:0] FCLR,
    input  logic              PUSH,
    input  logic              POP,
    input  logic              ERR_CLR,
    output logic [NFLAGS-1:0] FLAGS_OUT,
    output logic              CF,
    output logic              OF,
    output logic              NF,
    output logic              ZF,
    output logic [CW-1:0]     COUNT,
    output logic              EMPTY,
    output logic              FULL,
    output logic              OVF_ERR,
    output logic              UNF_ERR
);

    function automatic logic [NFLAGS-1:0] next_flags(
        input logic [NFLAGS-1:0] cur,
        input logic [NFLAGS-1:0] din,
        input logic [NFLAGS-1:0] m,
        input logic [NFLAGS-1:0] set,
        input logic [NFLAGS-1:0] clr
    );
        return (((cur & ~m) | (din & m)) | set) & ~clr;
    endfunction

    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [NFLAGS-1:0] lifo_top;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              pop_ok, ovf_ev, unf_ev;

    // The stack always saves the registered flags, never the in-flight value.
    flag_lifo #(
        .NFLAGS (NFLAGS),
        .DEPTH  (DEPTH)
    ) u_lifo (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .push_i  (PUSH),
        .pop_i   (POP),
        .din_i   (flags_q),
        .top_o   (lifo_top),
        .count_o (COUNT),
        .empty_o (EMPTY),
        .full_o  (FULL)
    );

    assign pop_ok = POP && !EMPTY;
    assign ovf_ev = PUSH && !POP && FULL;
    assign unf_ev = POP && EMPTY;

    always_comb begin
        flags_d = next_flags(flags_q, FLAGS_IN, FWE ? FMASK : '0, FSET, FCLR);
        if (pop_ok) begin
            flags_d = lifo_top;
        end
        ovf_d = ovf_ev || (ovf_q && !ERR_CLR);
        unf_d = unf_ev || (unf_q && !ERR_CLR);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            flags_q <= RESET_VAL;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign FLAGS_OUT = flags_q;
    assign OVF_ERR   = ovf_q;
    assign UNF_ERR   = unf_q;

    generate
        if (NFLAGS >= 4) begin : g_alias
            assign CF = flags_q[CF_IDX];
            assign OF = flags_q[OF_IDX];
            assign NF = flags_q[NF_IDX];
            assign ZF = flags_q[ZF_IDX];
        end else begin : g_no_alias
            assign CF = 1'b0;
            assign OF = 1'b0;
            assign NF = 1'b0;
            assign ZF = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_flag_stack_unit.sv
// Bench for flag_stack_unit: directed vector table, async-reset sequence, and
// randomized traffic against a queue-based reference model.
module tb_flag_stack_unit;
    import cpu_flags_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] FLAGS_IN = '0, FMASK = '0, FSET = '0, FCLR = '0;
    logic       FWE = 1'b0, PUSH = 1'b0, POP = 1'b0, ERR_CLR = 1'b0;
    logic [3:0] FLAGS_OUT;
    logic       CF, OF, NF, ZF;
    logic [2:0] COUNT;
    logic       EMPTY, FULL, OVF_ERR, UNF_ERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    flag_stack_unit #(.NFLAGS(4), .DEPTH(4), .RESET_VAL(4'b0000)) dut (
        .CLK(CLK), .RESET(RESET), .FLAGS_IN(FLAGS_IN), .FWE(FWE), .FMASK(FMASK),
        .FSET(FSET), .FCLR(FCLR), .PUSH(PUSH), .POP(POP), .ERR_CLR(ERR_CLR),
        .FLAGS_OUT(FLAGS_OUT), .CF(CF), .OF(OF), .NF(NF), .ZF(ZF), .COUNT(COUNT),
        .EMPTY(EMPTY), .FULL(FULL), .OVF_ERR(OVF_ERR), .UNF_ERR(UNF_ERR)
    );

    typedef struct {
        logic       push, pop, fwe;
        logic [3:0] fmask, fin, fset, fclr;
        logic       eclr;
        logic [3:0] eflags;
        int         ecount;
        logic       eovf, eunf;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [3:0] m_flags;
    logic [3:0] m_stk[$];
    logic       m_ovf, m_unf;

    function automatic vec_t mk(logic push, logic pop, logic fwe, logic [3:0] fmask,
                                logic [3:0] fin, logic [3:0] fset, logic [3:0] fclr,
                                logic eclr, logic [3:0] eflags, int ecount,
                                logic eovf, logic eunf);
        vec_t v;
        v.push = push; v.pop = pop; v.fwe = fwe; v.fmask = fmask; v.fin = fin;
        v.fset = fset; v.fclr = fclr; v.eclr = eclr; v.eflags = eflags;
        v.ecount = ecount; v.eovf = eovf; v.eunf = eunf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] ef, input int ec,
                               input logic eo, input logic eu);
        chk({tag, ".flags"}, 32'(FLAGS_OUT), 32'(ef));
        chk({tag, ".alias"}, 32'({CF, OF, NF, ZF}), 32'(ef));
        chk({tag, ".count"}, 32'(COUNT), 32'(ec));
        chk({tag, ".empty"}, 32'(EMPTY), 32'(ec == 0));
        chk({tag, ".full"}, 32'(FULL), 32'(ec == 4));
        chk({tag, ".ovf"}, 32'(OVF_ERR), 32'(eo));
        chk({tag, ".unf"}, 32'(UNF_ERR), 32'(eu));
    endtask

    task automatic drive(input logic push, input logic pop, input logic fwe,
                         input logic [3:0] fmask, input logic [3:0] fin,
                         input logic [3:0] fset, input logic [3:0] fclr, input logic eclr);
        PUSH = push; POP = pop; FWE = fwe; FMASK = fmask; FLAGS_IN = fin;
        FSET = fset; FCLR = fclr; ERR_CLR = eclr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Applies the flag rules to the currently driven inputs, as one clock edge would.
    task automatic model_step();
        logic [3:0] old, m, t;
        logic       ovf_ev, unf_ev;
        old = m_flags;
        m = FWE ? FMASK : 4'b0000;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (POP && m_stk.size() > 0) begin
            t = m_stk.pop_back();
            if (PUSH) m_stk.push_back(old);
            m_flags = t;
        end else begin
            if (POP) unf_ev = 1'b1;
            if (PUSH) begin
                if (m_stk.size() < 4) m_stk.push_back(old);
                else ovf_ev = 1'b1;
            end
            m_flags = (((old & ~m) | (FLAGS_IN & m)) | FSET) & ~FCLR;
        end
        if (ERR_CLR) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (ovf_ev) m_ovf = 1'b1;
        if (unf_ev) m_unf = 1'b1;
    endtask

    initial begin
        // Directed table: load, mask/set/clear, LIFO order, overflow, underflow,
        // exchange, pop priority, error-set-beats-clear, exchange while full.
        vecs.push_back(mk(0,0,1,4'hF,4'hA,4'h0,4'h0,0, 4'hA,0,0,0));
        vecs.push_back(mk(0,0,1,4'h3,4'h5,4'h4,4'h1,0, 4'hC,0,0,0));
        vecs.push_back(mk(0,0,1,4'hF,4'h1,4'h0,4'h0,0, 4'h1,0,0,0));
        vecs.push_back(mk(1,0,1,4'hF,4'h2,4'h0,4'h0,0, 4'h2,1,0,0));
        vecs.push_back(mk(1,0,1,4'hF,4'h4,4'h0,4'h0,0, 4'h4,2,0,0));
        vecs.push_back(mk(1,0,1,4'hF,4'h8,4'h0,4'h0,0, 4'h8,3,0,0));
        vecs.push_back(mk(1,0,0,4'h0,4'h0,4'h0,4'h0,0, 4'h8,4,0,0));
        vecs.push_back(mk(1,0,0,4'h0,4'h0,4'h0,4'h0,0, 4'h8,4,1,0));
        vecs.push_back(mk(0,1,0,4'h0,4'h0,4'h0,4'h0,0, 4'h8,3,1,0));
        vecs.push_back(mk(0,1,0,4'h0,4'h0,4'h0,4'h0,0, 4'h4,2,1,0));
        vecs.push_back(mk(0,1,0,4'h0,4'h0,4'h0,4'h0,0, 4'h2,1,1,0));
        vecs.push_back(mk(0,1,0,4'h0,4'h0,4'h0,4'h0,0, 4'h1,0,1,0));
        vecs.push_back(mk(0,0,0,4'h0,4'h0,4'h0,4'h0,1, 4'h1,0,0,0));
        vecs.push_back(mk(0,1,1,4'hF,4'h6,4'h0,4'h0,0, 4'h6,0,0,1));
        vecs.push_back(mk(0,0,0,4'h0,4'h0,4'h0,4'h0,1, 4'h6,0,0,0));
        vecs.push_back(mk(0,0,1,4'hF,4'h9,4'h0,4'h0,0, 4'h9,0,0,0));
        vecs.push_back(mk(1,0,0,4'h0,4'h0,4'h0,4'h0,0, 4'h9,1,0,0));
        vecs.push_back(mk(0,0,1,4'hF,4'h3,4'h0,4'h0,0, 4'h3,1,0,0));
        vecs.push_back(mk(1,1,0,4'h0,4'h0,4'h0,4'h0,0, 4'h9,1,0,0));
        vecs.push_back(mk(0,1,0,4'h0,4'h0,4'h0,4'h0,0, 4'h3,0,0,0));
        vecs.push_back(mk(0,0,1,4'hF,4'hF,4'h0,4'h0,0, 4'hF,0,0,0));
        vecs.push_back(mk(1,0,0,4'h0,4'h0,4'h0,4'h0,0, 4'hF,1,0,0));
        vecs.push_back(mk(0,0,1,4'hF,4'h0,4'h0,4'h0,0, 4'h0,1,0,0));
        vecs.push_back(mk(0,1,1,4'hF,4'h0,4'h0,4'hF,0, 4'hF,0,0,0));
        vecs.push_back(mk(0,1,0,4'h0,4'h0,4'h0,4'h0,1, 4'hF,0,0,1));
        vecs.push_back(mk(1,1,0,4'h0,4'h0,4'h0,4'h0,0, 4'hF,1,0,1));
        vecs.push_back(mk(1,0,1,4'hF,4'h1,4'h0,4'h0,0, 4'h1,2,0,1));
        vecs.push_back(mk(1,0,1,4'hF,4'h2,4'h0,4'h0,0, 4'h2,3,0,1));
        vecs.push_back(mk(1,0,1,4'hF,4'h4,4'h0,4'h0,0, 4'h4,4,0,1));
        vecs.push_back(mk(1,1,0,4'h0,4'h0,4'h0,4'h0,0, 4'h2,4,0,1));
        vecs.push_back(mk(0,1,0,4'h0,4'h0,4'h0,4'h0,1, 4'h4,3,0,0));

        RESET = 1'b0;
        tick();
        tick();
        check_state("reset", 4'h0, 0, 0, 0);
        RESET = 1'b1;
        #2;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].push, vecs[i].pop, vecs[i].fwe, vecs[i].fmask, vecs[i].fin,
                  vecs[i].fset, vecs[i].fclr, vecs[i].eclr);
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].eflags, vecs[i].ecount,
                        vecs[i].eovf, vecs[i].eunf);
        end

        // Asynchronous reset mid-cycle with a non-empty stack and push pending.
        drive(1,0,0,4'h0,4'h0,4'h0,4'h0,0);
        #2;
        RESET = 1'b0;
        #1;
        check_state("async_rst", 4'h0, 0, 0, 0);
        #1;
        RESET = 1'b1;
        drive(1,0,1,4'hF,4'h5,4'h0,4'h0,0);
        tick();
        check_state("post_rst_push", 4'h5, 1, 0, 0);
        drive(0,1,0,4'h0,4'h0,4'h0,4'h0,0);
        tick();
        check_state("post_rst_pop", 4'h0, 0, 0, 0);

        // Randomized traffic against the reference model from a clean reset.
        drive(0,0,0,4'h0,4'h0,4'h0,4'h0,0);
        #2;
        RESET = 1'b0;
        #2;
        RESET = 1'b1;
        m_flags = 4'h0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, 1'(($urandom & 1)),
                  4'($urandom), 4'($urandom), 4'($urandom & $urandom & $urandom),
                  4'($urandom & $urandom & $urandom), $urandom_range(0, 7) == 0);
            model_step();
            tick();
            check_state("rand", m_flags, m_stk.size(), m_ovf, m_unf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
